// File: rtl/dll_tx_framer_pkg.sv
// Shared definitions for the data-link transmit framer: default widths, checksum seed
// and FSM state encoding.
package dll_tx_framer_pkg;

    localparam int unsigned DefDataW   = 12;
    localparam int unsigned DefSeqW    = 10;
    localparam logic [11:0] DefChkSeed = 12'hFFF;
    localparam int unsigned NumVc      = 4;

    // Header word layout: vc in the top two bits, sequence number below.
    localparam int unsigned HdrVcMsb  = 11;
    localparam int unsigned HdrVcLsb  = 10;
    localparam int unsigned HdrSeqMsb = 9;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StPop  = 3'd1,
        StCapt = 3'd2,
        StHdr  = 3'd3,
        StPay  = 3'd4,
        StChk  = 3'd5
    } state_e;

endpackage

// File: rtl/dll_tx_framer_rr_arb4.sv
// Combinational 4-way round-robin arbiter: grants the first requester at or after ptr_i,
// returning both a one-hot grant and its encoded index.
module dll_tx_framer_rr_arb4 (
    input  logic [3:0] req_i,
    input  logic [1:0] ptr_i,
    output logic [3:0] gnt_o,
    output logic [1:0] vc_o,
    output logic       valid_o
);

    logic [1:0] idx;

    // Scan from the farthest offset down so the closest requester to ptr_i wins.
    always_comb begin
        gnt_o   = 4'b0000;
        vc_o    = 2'd0;
        valid_o = 1'b0;
        idx     = ptr_i;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr_i + i[1:0];
            if (req_i[idx]) begin
                gnt_o      = 4'b0000;
                gnt_o[idx] = 1'b1;
                vc_o       = idx;
                valid_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dll_tx_framer.sv
// Drains four per-class FIFOs round-robin, one word per frame, and emits
// HDR/PAYLOAD/CHK frames on a valid/ready link.
module dll_tx_framer
    import dll_tx_framer_pkg::*;
#(
    parameter int unsigned       DataW   = DefDataW,
    parameter int unsigned       SeqW    = DefSeqW,
    parameter logic [DataW-1:0]  ChkSeed = DefChkSeed
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              link_up_i,
    input  logic [3:0]        empty_i,
    input  logic [DataW-1:0]  fifo_data0_i,
    input  logic [DataW-1:0]  fifo_data1_i,
    input  logic [DataW-1:0]  fifo_data2_i,
    input  logic [DataW-1:0]  fifo_data3_i,
    output logic [3:0]        pop_o,
    output logic [DataW-1:0]  tx_data_o,
    output logic              tx_valid_o,
    output logic              tx_sof_o,
    output logic              tx_eof_o,
    input  logic              tx_ready_i,
    output logic [15:0]       frame_cnt_o,
    output logic              busy_o
);

    state_e             state_q, state_d;
    logic [1:0]         vc_q, vc_d;
    logic [3:0]         gnt_q, gnt_d;
    logic [DataW-1:0]   payload_q, payload_d;
    logic [SeqW-1:0]    seq_q, seq_d;
    logic [1:0]         rr_ptr_q, rr_ptr_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;

    logic [3:0]         arb_gnt;
    logic [1:0]         arb_vc;
    logic               arb_valid;
    logic [DataW-1:0]   fifo_sel;
    logic [DataW-1:0]   hdr_word;
    logic               xfer;

    dll_tx_framer_rr_arb4 u_arb (
        .req_i   (~empty_i),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (arb_gnt),
        .vc_o    (arb_vc),
        .valid_o (arb_valid)
    );

    always_comb begin
        case (vc_q)
            2'd0:    fifo_sel = fifo_data0_i;
            2'd1:    fifo_sel = fifo_data1_i;
            2'd2:    fifo_sel = fifo_data2_i;
            default: fifo_sel = fifo_data3_i;
        endcase
    end

    assign hdr_word = {vc_q, seq_q};
    assign xfer     = tx_valid_o && tx_ready_i;

    always_comb begin
        state_d     = state_q;
        vc_d        = vc_q;
        gnt_d       = gnt_q;
        payload_d   = payload_q;
        seq_d       = seq_q;
        rr_ptr_d    = rr_ptr_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            StIdle: begin
                if (link_up_i && arb_valid) begin
                    vc_d    = arb_vc;
                    gnt_d   = arb_gnt;
                    state_d = StPop;
                end
            end
            StPop:  state_d = StCapt;
            StCapt: begin
                // FIFO output is valid the cycle after the pop.
                payload_d = fifo_sel;
                state_d   = StHdr;
            end
            StHdr:  if (xfer) state_d = StPay;
            StPay:  if (xfer) state_d = StChk;
            StChk: begin
                if (xfer) begin
                    seq_d       = seq_q + 1'b1;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    rr_ptr_d    = vc_q + 2'd1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pop_o      = 4'b0000;
        tx_data_o  = '0;
        tx_valid_o = 1'b0;
        tx_sof_o   = 1'b0;
        tx_eof_o   = 1'b0;
        case (state_q)
            StPop: pop_o = gnt_q;
            StHdr: begin
                tx_data_o  = hdr_word;
                tx_valid_o = 1'b1;
                tx_sof_o   = 1'b1;
            end
            StPay: begin
                tx_data_o  = payload_q;
                tx_valid_o = 1'b1;
            end
            StChk: begin
                tx_data_o  = ChkSeed ^ hdr_word ^ payload_q;
                tx_valid_o = 1'b1;
                tx_eof_o   = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy_o      = (state_q != StIdle);
    assign frame_cnt_o = frame_cnt_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            vc_q        <= 2'd0;
            gnt_q       <= 4'b0000;
            payload_q   <= '0;
            seq_q       <= '0;
            rr_ptr_q    <= 2'd0;
            frame_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            vc_q        <= vc_d;
            gnt_q       <= gnt_d;
            payload_q   <= payload_d;
            seq_q       <= seq_d;
            rr_ptr_q    <= rr_ptr_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

endmodule
